// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Configuration-chain bitstream writer. Accepts WORD_W-bit words over a
// valid/ready stream and serializes them MSB-first onto ccff_head. The chain
// shift enable is asserted for exactly CHAIN_LEN bits per load. The final
// partial word keeps only its MSBs. tail_parity accumulates the XOR of every
// ccff_tail bit captured while the chain is enabled.
//
// Ports:
//   prog_clk     configuration clock (rising edge)
//   pReset       synchronous active-high reset
//   start        begin a load (honoured only when idle)
//   cfg_data     configuration word, bit [WORD_W-1] shifted first
//   cfg_valid    cfg_data valid
//   cfg_ready    word accepted this cycle when cfg_valid is also high
//   ccff_head    serial data into the chain (registered)
//   ccff_clk_en  chain shift enable, aligned with ccff_head
//   ccff_tail    serial data out of the chain end
//   busy         load in progress (SHIFT or DONE)
//   done         one-cycle completion pulse
//   tail_parity  XOR of ccff_tail bits captured during the last load
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  localparam int SW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q;       // bits not yet presented, MSB next
  logic [SW-1:0]     scnt_q;       // number of valid bits left in sreg_q
  logic [CNT_W-1:0]  bits_acc_q;   // bits accepted from words this load
  logic [CNT_W-1:0]  bits_sent_q;  // bits captured by the chain this load
  logic              head_q, en_q, par_q;

  logic [CNT_W-1:0]  rem;
  logic [SW-1:0]     nbits;
  logic              accept, last_bit;

  always_comb begin
    rem      = CNT_W'(CHAIN_LEN) - bits_acc_q;
    nbits    = (32'(rem) >= WORD_W) ? SW'(WORD_W) : SW'(rem);
    // The bit currently on ccff_head is already out of sreg_q, so an empty
    // sreg_q means the last held bit is shifting now: accepting here gives
    // back-to-back words with no bubble.
    cfg_ready = (state_q == SHIFT) && (scnt_q == '0) &&
                (bits_acc_q != CNT_W'(CHAIN_LEN));
    accept   = cfg_valid && cfg_ready;
    last_bit = en_q && (bits_sent_q == CNT_W'(CHAIN_LEN - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sreg_q      <= '0;
      scnt_q      <= '0;
      bits_acc_q  <= '0;
      bits_sent_q <= '0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      en_q <= 1'b0;
      // The chain captures head and we sample tail on the same edge.
      if (en_q) begin
        par_q       <= par_q ^ ccff_tail;
        bits_sent_q <= bits_sent_q + 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          sreg_q      <= '0;
          scnt_q      <= '0;
          bits_acc_q  <= '0;
          bits_sent_q <= '0;
          par_q       <= 1'b0;
        end
        SHIFT: begin
          if (accept) begin
            // MSB goes straight to the output; the rest waits in sreg_q.
            // Discarded LSBs of a partial word are never counted in scnt_q.
            head_q     <= cfg_data[WORD_W-1];
            en_q       <= 1'b1;
            sreg_q     <= cfg_data << 1;
            scnt_q     <= nbits - SW'(1);
            bits_acc_q <= bits_acc_q + CNT_W'(nbits);
          end else if (scnt_q != '0) begin
            head_q <= sreg_q[WORD_W-1];
            en_q   <= 1'b1;
            sreg_q <= sreg_q << 1;
            scnt_q <= scnt_q - SW'(1);
          end
          // otherwise stall: enable low, head holds
        end
        default: ;
      endcase
    end
  end

  assign ccff_head   = head_q;
  // Gate with reset so the chain stops shifting in the reset cycle itself.
  assign ccff_clk_en = en_q && !pReset;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign tail_parity = par_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic pReset;

  // DUT A: WORD_W=4, CHAIN_LEN=10
  logic       start_a, valid_a, ready_a, head_a, en_a, busy_a, done_a, par_a;
  logic [3:0] data_a;
  logic       tail_a;

  // DUT B: WORD_W=8, CHAIN_LEN=8
  logic       start_b, valid_b, ready_b, head_b, en_b, busy_b, done_b, par_b;
  logic [7:0] data_b;
  logic       tail_b;

  ccff_chain_loader #(.WORD_W(4), .CHAIN_LEN(10)) dut_a (
    .prog_clk(clk), .pReset(pReset), .start(start_a), .cfg_data(data_a),
    .cfg_valid(valid_a), .cfg_ready(ready_a), .ccff_head(head_a),
    .ccff_clk_en(en_a), .ccff_tail(tail_a), .busy(busy_a), .done(done_a),
    .tail_parity(par_a)
  );

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut_b (
    .prog_clk(clk), .pReset(pReset), .start(start_b), .cfg_data(data_b),
    .cfg_valid(valid_b), .cfg_ready(ready_b), .ccff_head(head_b),
    .ccff_clk_en(en_b), .ccff_tail(tail_b), .busy(busy_b), .done(done_b),
    .tail_parity(par_b)
  );

  // Behavioural 10-flop chain behind DUT A; first bit shifted ends at [9].
  logic [9:0] chain;
  logic       preload_req;
  logic [9:0] preload_val;
  always @(posedge clk) begin
    if (preload_req)  chain <= preload_val;
    else if (en_a)    chain <= {chain[8:0], head_a};
  end
  assign tail_a = chain[9];
  assign tail_b = 1'b0;

  logic [3:0] wd [3] = '{4'hA, 4'h5, 4'hF};
  localparam logic [9:0] EXP_SEQ = 10'b1010010111;

  int checks = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full load on DUT A. Cycle 1 is the cycle after the start edge.
  task automatic load_a(input int gap, input bit extra,
                        output logic [9:0] seq, output int nen, output int nacc,
                        output int dcyc, output logic par, output bit hold_ok);
    int   idx, gapcnt;
    logic last_h;
    idx = 0; gapcnt = 0; seq = '0; nen = 0; nacc = 0; dcyc = -1;
    par = 1'bx; hold_ok = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    last_h = head_a;
    for (int c = 1; c <= 60; c++) begin
      if (done_a) begin dcyc = c; par = par_a; break; end
      valid_a = 1'b0; data_a = 4'h0;
      if (idx < 3 && gapcnt == 0) begin valid_a = 1'b1; data_a = wd[idx]; end
      else if (idx >= 3 && extra) begin valid_a = 1'b1; data_a = 4'hC; end
      if (gapcnt > 0) gapcnt--;
      start_a = extra && (c == 4);
      if (en_a) begin seq = {seq[8:0], head_a}; nen++; last_h = head_a; end
      else if (busy_a && head_a !== last_h) hold_ok = 1'b0;
      if (valid_a && ready_a) begin
        nacc++; idx++;
        if (idx == 1) gapcnt = gap;
      end
      step();
    end
    start_a = 1'b0; valid_a = 1'b0;
  endtask

  logic [9:0] seq;
  logic [7:0] seq8;
  int         nen, nacc, dcyc, idx;
  logic       par;
  bit         hold_ok;

  initial begin
    pReset = 1'b1; start_a = 0; valid_a = 0; data_a = 0;
    start_b = 0; valid_b = 0; data_b = 0;
    preload_req = 1'b1; preload_val = 10'b1101001001;
    step(); step();
    preload_req = 1'b0;

    // reset values
    chk("rst_ready", ready_a, 0); chk("rst_head", head_a, 0);
    chk("rst_en", en_a, 0);       chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);   chk("rst_par", par_a, 0);
    chk("rst_b_busy", busy_b, 0); chk("rst_b_ready", ready_b, 0);
    pReset = 1'b0;

    // cfg_valid in IDLE is ignored
    valid_a = 1'b1; data_a = 4'hA; step();
    chk("idle_ready", ready_a, 0); chk("idle_busy", busy_a, 0);
    valid_a = 1'b0;

    // load 1: preload 1101001001 has five ones -> parity 1
    preload_req = 1'b1; preload_val = 10'b1101001001; step(); preload_req = 1'b0;
    load_a(0, 0, seq, nen, nacc, dcyc, par, hold_ok);
    chk("l1_seq", seq, EXP_SEQ);   chk("l1_nen", nen, 10);
    chk("l1_nacc", nacc, 3);       chk("l1_done_cyc", dcyc, 12);
    chk("l1_par", par, 1);         chk("l1_chain", chain, EXP_SEQ);
    step();
    chk("l1_idle_busy", busy_a, 0); chk("l1_idle_done", done_a, 0);

    // load 2: chain holds 1010010111 (six ones) -> parity 0
    load_a(0, 0, seq, nen, nacc, dcyc, par, hold_ok);
    chk("l2_seq", seq, EXP_SEQ);   chk("l2_par", par, 0);
    chk("l2_par_stable", par_a, 0);
    step();

    // load 3: 5-cycle valid gap after word 1
    load_a(5, 0, seq, nen, nacc, dcyc, par, hold_ok);
    chk("gap_seq", seq, EXP_SEQ);  chk("gap_nen", nen, 10);
    chk("gap_done_cyc", dcyc, 14); chk("gap_hold", hold_ok, 1);
    step();

    // load 4: start pulsed mid-load and extra words offered
    load_a(0, 1, seq, nen, nacc, dcyc, par, hold_ok);
    chk("ext_nacc", nacc, 3);      chk("ext_seq", seq, EXP_SEQ);
    chk("ext_done_cyc", dcyc, 12); chk("ext_chain", chain, EXP_SEQ);
    step();
    chk("ext_idle", busy_a, 0);

    // reset after bit 6
    start_a = 1'b1; step(); start_a = 1'b0;
    nen = 0; idx = 0;
    for (int c = 0; c < 40 && nen < 6; c++) begin
      valid_a = (idx < 3); data_a = wd[idx < 3 ? idx : 2];
      if (en_a) nen++;
      if (nen < 6) begin
        if (valid_a && ready_a) idx++;
        step();
      end
    end
    chk("rst6_reached", nen, 6);
    pReset = 1'b1; valid_a = 1'b0; step();
    chk("rst6_ready", ready_a, 0); chk("rst6_head", head_a, 0);
    chk("rst6_en", en_a, 0);       chk("rst6_busy", busy_a, 0);
    chk("rst6_done", done_a, 0);   chk("rst6_par", par_a, 0);
    pReset = 1'b0;
    load_a(0, 0, seq, nen, nacc, dcyc, par, hold_ok);
    chk("rl_seq", seq, EXP_SEQ);   chk("rl_nen", nen, 10);
    chk("rl_done_cyc", dcyc, 12);  chk("rl_chain", chain, EXP_SEQ);
    step();

    // DUT B: single 8-bit word 0x81
    start_b = 1'b1; step(); start_b = 1'b0;
    valid_b = 1'b1; data_b = 8'h81;
    seq8 = '0; nen = 0; dcyc = -1;
    for (int c = 1; c <= 30; c++) begin
      bit acc;
      if (done_b) begin dcyc = c; break; end
      if (en_b) begin seq8 = {seq8[6:0], head_b}; nen++; end
      acc = valid_b && ready_b;
      step();
      if (acc) valid_b = 1'b0;
    end
    valid_b = 1'b0;
    chk("b_seq", seq8, 8'h81);     chk("b_nen", nen, 8);
    chk("b_done_cyc", dcyc, 10);   chk("b_par", par_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
